// File: rtl/key_cmd_scheduler_if.sv
// key_cmd_scheduler_if: keyboard event inputs and command FIFO handshake bundle
interface key_cmd_scheduler_if;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic         cmd_repeat;
    logic [7:0]   drop_cnt;
    modport master (
        output key_valid, last_change, key_down, cmd_ready,
        input  cmd_valid, cmd_code, cmd_repeat, drop_cnt
    );
    modport slave (
        input  key_valid, last_change, key_down, cmd_ready,
        output cmd_valid, cmd_code, cmd_repeat, drop_cnt
    );
endinterface

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: turns key presses and A/D auto-repeat into a 4-entry command FIFO
module key_cmd_scheduler #(
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input logic clk,
    input logic rst,
    key_cmd_scheduler_if.slave bus
);
    localparam int MAXC = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic tracked, tracked_nx;
    logic [3:0] mem [4];
    logic [1:0] rd, wr;
    logic [2:0] count;
    logic [7:0] drop_q;
    logic [2:0] press_code;
    logic is_press, is_esc, is_move, held, expire, full, pop;
    logic push_press, push_rep, push, drop;
    logic [3:0] push_data;
    assign press_code = !(bus.key_valid && bus.key_down[bus.last_change]) ? 3'd0 :
                        bus.last_change == 9'h076 ? 3'd1 :
                        bus.last_change == 9'h05A ? 3'd2 :
                        bus.last_change == 9'h066 ? 3'd3 :
                        bus.last_change == 9'h059 ? 3'd4 :
                        bus.last_change == 9'h01C ? 3'd5 :
                        bus.last_change == 9'h023 ? 3'd6 : 3'd0;
    assign is_press = press_code != 3'd0;
    assign is_esc = press_code == 3'd1;
    assign is_move = press_code == 3'd5 || press_code == 3'd6;
    // tracked: 0 = A, 1 = D
    assign held = bus.key_down[tracked ? 9'h023 : 9'h01C];
    // the counter holds at 1 while a repeat waits for a free push slot
    assign expire = state != IDLE && held && cnt <= CW'(1);
    assign full = count == 3'd4;
    assign pop = count != 3'd0 && bus.cmd_ready;
    assign push_press = is_press && !is_esc && (!full || pop);
    assign drop = is_press && !is_esc && full && !pop;
    assign push_rep = expire && !is_press && (!full || pop);
    assign push = push_press || push_rep;
    assign push_data = push_press ? {press_code, 1'b0} : {tracked ? 3'd6 : 3'd5, 1'b1};
    // repeat FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tracked <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            tracked <= tracked_nx;
        end
    end
    // repeat FSM next state: ESC, then new A/D press, then release, then countdown
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        tracked_nx = tracked;
        if (is_esc) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else if (is_move) begin
            state_nx = DELAY;
            cnt_nx = CW'(REPEAT_DELAY);
            tracked_nx = press_code == 3'd6;
        end else if (state != IDLE && !held) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else if (push_rep) begin
            state_nx = REPEAT;
            cnt_nx = CW'(REPEAT_RATE);
        end else if (state != IDLE && !expire) begin
            cnt_nx = cnt - CW'(1);
        end
    end
    // command FIFO and drop counter; ESC replaces the whole contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            rd <= '0;
            wr <= '0;
            count <= '0;
            drop_q <= '0;
        end else if (is_esc) begin
            mem[0] <= {3'd1, 1'b0};
            rd <= 2'd0;
            wr <= 2'd1;
            count <= 3'd1;
        end else begin
            if (push) begin
                mem[wr] <= push_data;
                wr <= wr + 2'd1;
            end
            if (pop) rd <= rd + 2'd1;
            count <= count + 3'(push) - 3'(pop);
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end
    assign bus.cmd_valid = count != 3'd0;
    assign bus.cmd_code = count != 3'd0 ? mem[rd][3:1] : 3'd0;
    assign bus.cmd_repeat = count != 3'd0 ? mem[rd][0] : 1'b0;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb_key_cmd_scheduler: scoreboard bench for key_cmd_scheduler (REPEAT_DELAY=8, REPEAT_RATE=4)
module tb_key_cmd_scheduler;
    localparam logic [8:0] ESC = 9'h076, ENTER = 9'h05A, BKSP = 9'h066, SHIFT = 9'h059;
    localparam logic [8:0] KA = 9'h01C, KD = 9'h023, KQ = 9'h015;
    typedef struct {
        logic [2:0] code;
        logic       rep;
        int         at;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    key_cmd_scheduler_if bus ();
    key_cmd_scheduler #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, req, cyc);
        end
    endtask
    task automatic want(input logic [2:0] code, input logic rep, input int at);
        exp_t e;
        e.code = code;
        e.rep = rep;
        e.at = at;
        exp_q.push_back(e);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(input logic [8:0] sc, input bit hold);
        bus.key_down[sc] = 1'b1;
        bus.last_change = sc;
        bus.key_valid = 1'b1;
        tick(1);
        bus.key_valid = 1'b0;
        if (!hold) bus.key_down[sc] = 1'b0;
    endtask
    task automatic lift(input logic [8:0] sc);
        bus.key_down[sc] = 1'b0;
        bus.last_change = sc;
        bus.key_valid = 1'b1;
        tick(1);
        bus.key_valid = 1'b0;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_valid", bus.cmd_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("code", bus.cmd_code, e.code);
                check("repeat", bus.cmd_repeat, e.rep);
                if (e.at >= 0) check("cycle", cyc, e.at);
            end
        end
    end
    initial begin
        int t;
        bus.key_valid = 1'b0;
        bus.last_change = '0;
        bus.key_down = '0;
        bus.cmd_ready = 1'b1;
        #1;
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_code", bus.cmd_code, 0);
        check("rst_repeat", bus.cmd_repeat, 0);
        check("rst_drop", bus.drop_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        // single ENTER press, one-cycle visibility; unknown key and release give nothing
        t = cyc;
        want(3'd2, 1'b0, t + 1);
        press(ENTER, 1'b0);
        tick(1);
        check("enter_gone", bus.cmd_valid, 0);
        press(KQ, 1'b1);
        lift(KQ);
        tick(3);
        check("s1_q_empty", exp_q.size(), 0);
        // held A: press then repeats, stop after release
        t = cyc;
        want(3'd5, 1'b0, t + 1);
        want(3'd5, 1'b1, t + 9);
        want(3'd5, 1'b1, t + 13);
        want(3'd5, 1'b1, t + 17);
        press(KA, 1'b1);
        tick(17);
        lift(KA);
        tick(20);
        check("s2_q_empty", exp_q.size(), 0);
        // FIFO overflow and ESC flush
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) press(SHIFT, 1'b0);
        check("ovf_drop", bus.drop_cnt, 1);
        check("ovf_valid", bus.cmd_valid, 1);
        check("ovf_code", bus.cmd_code, 4);
        press(ESC, 1'b0);
        check("esc_code", bus.cmd_code, 1);
        check("esc_repeat", bus.cmd_repeat, 0);
        check("esc_drop", bus.drop_cnt, 1);
        want(3'd1, 1'b0, cyc);
        bus.cmd_ready = 1'b1;
        tick(1);
        check("esc_single", bus.cmd_valid, 0);
        // repeat held pending while full, then pushed once space appears
        bus.cmd_ready = 1'b0;
        t = cyc;
        want(3'd6, 1'b0, t + 12);
        want(3'd4, 1'b0, t + 13);
        want(3'd4, 1'b0, t + 14);
        want(3'd4, 1'b0, t + 15);
        want(3'd6, 1'b1, t + 16);
        want(3'd6, 1'b1, t + 17);
        press(KD, 1'b1);
        for (int i = 0; i < 3; i++) press(SHIFT, 1'b0);
        tick(7);
        check("full_drop", bus.drop_cnt, 1);
        check("full_head", bus.cmd_code, 6);
        check("full_head_rep", bus.cmd_repeat, 0);
        tick(1);
        bus.cmd_ready = 1'b1;
        tick(5);
        lift(KD);
        tick(15);
        check("s4_q_empty", exp_q.size(), 0);
        // retarget from A to D while A repeats
        t = cyc;
        want(3'd5, 1'b0, t + 1);
        want(3'd5, 1'b1, t + 9);
        want(3'd5, 1'b1, t + 13);
        want(3'd5, 1'b1, t + 17);
        want(3'd6, 1'b0, t + 21);
        want(3'd6, 1'b1, t + 29);
        press(KA, 1'b1);
        tick(19);
        press(KD, 1'b1);
        tick(9);
        lift(KD);
        lift(KA);
        tick(15);
        check("s5_q_empty", exp_q.size(), 0);
        // drop counter saturation
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 260; i++) press(SHIFT, 1'b0);
        check("sat_drop", bus.drop_cnt, 255);
        press(ESC, 1'b0);
        check("sat_esc_drop", bus.drop_cnt, 255);
        want(3'd1, 1'b0, cyc);
        bus.cmd_ready = 1'b1;
        tick(2);
        // asynchronous reset mid-DELAY with two entries queued
        bus.cmd_ready = 1'b0;
        press(KA, 1'b1);
        press(ENTER, 1'b0);
        check("pre_rst_valid", bus.cmd_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.cmd_valid, 0);
        check("mid_rst_code", bus.cmd_code, 0);
        check("mid_rst_drop", bus.drop_cnt, 0);
        tick(1);
        rst = 1'b0;
        bus.cmd_ready = 1'b1;
        tick(20);
        check("post_rst_idle", bus.cmd_valid, 0);
        lift(KA);
        want(3'd2, 1'b0, cyc + 1);
        press(ENTER, 1'b0);
        tick(3);
        check("s6_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter REPEAT_DELAY, default 50000000, cycles from a movement-key press to its first auto-repeat.
REQ-002 Parameter REPEAT_RATE, default 10000000, cycles between later auto-repeats.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port key_valid  input  1  one-cycle strobe from the keyboard decoder: last_change updated.
REQ-006 Port last_change  input  9  scan code of the key that last changed.
REQ-007 Port key_down  input  512  held-key bitmap from the keyboard decoder.
REQ-008 Port cmd_ready  input  1  consumer (game FSM) accepts the head command.
REQ-009 Port cmd_valid  output  1  FIFO not empty.
REQ-010 Port cmd_code  output  3  head command: 1 ESC, 2 ENTER, 3 BACKSPACE, 4 SHIFT, 5 LEFT (A, 0x1C), 6 RIGHT (D, 0x23); 0 when empty.
REQ-011 Port cmd_repeat  output  1  head command is an auto-repeat, not a press.
REQ-012 Port drop_cnt  output  8  saturating count of dropped press events.

Function
REQ-013 Press event: key_valid=1, key_down[last_change]=1, and last_change in {0x76, 0x5A, 0x66, 0x59, 0x1C, 0x23}; other codes and releases produce no command.
REQ-014 Command FIFO: 4 entries of {code[2:0], repeat}; head drives cmd_code/cmd_repeat; cmd_valid=!empty.
REQ-015 Pop occurs when cmd_valid and cmd_ready are both 1; cmd_ready while empty has no effect.
REQ-016 Push-to-visible latency: 1 cycle (push in cycle N gives cmd_valid=1 in N+1 if the FIFO was empty).
REQ-017 Push while full is accepted only when a pop occurs in the same cycle; occupancy is then unchanged.
REQ-018 A press event that cannot be pushed is dropped and drop_cnt increments, saturating at 255.
REQ-019 ESC press: FIFO flushed and ESC written as the sole entry in the same cycle, regardless of fullness; never dropped; no drop_cnt change; repeat FSM forced to IDLE.
REQ-020 Repeat FSM states: IDLE, DELAY, REPEAT; tracks one movement key (A or D).
REQ-021 IDLE -> DELAY on an A/D press; tracked key set; counter starts REPEAT_DELAY.
REQ-022 A/D press in DELAY or REPEAT: retarget to the new key, reload REPEAT_DELAY, enter DELAY.
REQ-023 DELAY: counter expiry raises a repeat request; then REPEAT state with counter reloaded to REPEAT_RATE.
REQ-024 REPEAT: each expiry raises a repeat request and reloads REPEAT_RATE.
REQ-025 Any state: key_down[tracked]=0 -> IDLE the next cycle; a pending repeat request is cancelled.
REQ-026 Repeat-request push: same cycle as counter expiry, {tracked code, repeat=1}.
REQ-027 Same-cycle press event and repeat request: press pushed; repeat stays pending (counter held) and retries each cycle.
REQ-028 Repeat request with FIFO full and no pop: held pending (counter held), never dropped, no drop_cnt change.
REQ-029 At most one push per cycle.

Reset
REQ-030 rst=1 asynchronously clears: FIFO empty, cmd_valid=0, cmd_code=0, cmd_repeat=0, drop_cnt=0, FSM=IDLE, counter=0, pending request cleared.
REQ-031 rst asserted mid-repeat or with FIFO non-empty discards all state; first command after release needs a new press event.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4, cmd_ready=1 unless stated)
REQ-032 ENTER press strobe in cycle 10 -> cmd_valid=1, cmd_code=2, cmd_repeat=0 in cycle 11 only; FIFO empty in cycle 12.
REQ-033 Press A in cycle 10, hold -> code 5/repeat 0 in 11; code 5/repeat 1 in 19, 23, 27; after release in cycle 28, no further commands.
REQ-034 cmd_ready=0; 5 SHIFT presses -> 4 entries held, drop_cnt=1; then ESC press -> one entry, code 1; drop_cnt stays 1.
REQ-035 Hold D, cmd_ready=0, FIFO full at repeat expiry -> no push, drop_cnt=0; cmd_ready=1 -> repeat (code 6, repeat 1) appears after the 4 queued entries.
REQ-036 Hold A to REPEAT, then press D in cycle 30 -> code 6/repeat 0 in 31; next repeat is code 6 in cycle 39; no code 5 repeats after cycle 30.
REQ-037 rst pulse while DELAY counts with 2 entries queued -> cmd_valid=0 immediately, drop_cnt=0, no repeat output while A still held.
